map_history_buffer: RTL and testbench
=====================================

MAP_HISTORY_BUFFER -- requirements
Module: map_history_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of rename-history entries (power of two, >=2).
REQ-002 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-003 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-004 SHALL have ports record_valid in 1 / record_ready out 1  rename-time mapping push handshake.
REQ-005 SHALL have ports record_arch_reg_tag in arch_reg_tag_t, record_old_phys_reg_tag in phys_reg_tag_t, record_new_phys_reg_tag in phys_reg_tag_t  mapping being replaced/installed.
REQ-006 SHALL have port record_index out hist_index_t  index the next accepted record occupies (checkpoint handle for branches).
REQ-007 SHALL have ports commit_valid in 1, commit_free_valid out 1, commit_free_phys_reg_tag out phys_reg_tag_t  oldest-entry retirement, old tag to free list.
REQ-008 SHALL have ports rollback_valid in 1, rollback_index in hist_index_t  squash request; rollback_index is the oldest entry to kill.
REQ-009 SHALL have ports kill_map_valid out 1, kill_map_dest_arch_reg_tag out arch_reg_tag_t, kill_map_old_dest_phys_reg_tag out phys_reg_tag_t, kill_map_new_dest_phys_reg_tag out phys_reg_tag_t  undo stream to the map table.
REQ-010 SHALL have ports busy out 1 (walk in progress), empty out 1, full out 1.

Function
REQ-011 SHALL store entries in a circular buffer with head (oldest) and tail (next free) pointers of log2(DEPTH)+1 bits; extra MSB distinguishes full from empty.
REQ-012 SHALL set empty when pointers equal, full when indices equal and MSBs differ.
REQ-013 SHALL drive record_ready = ~full & state==IDLE & ~rollback_valid.
REQ-014 SHALL, on record_valid & record_ready, write entry at tail and increment tail at the clock edge; record_index = tail index, combinational.
REQ-015 SHALL drive commit_free_valid = commit_valid & ~empty and commit_free_phys_reg_tag = head entry old tag, combinational; on that condition head increments.
REQ-016 SHALL ignore commit_valid when empty (no pop, commit_free_valid low).
REQ-017 SHALL permit simultaneous record and commit in one cycle, including when full is deasserted by the same-cycle commit only on the following cycle.
REQ-018 SHALL implement FSM states IDLE and WALK.
REQ-019 SHALL in IDLE, on rollback_valid with rollback_index inside [head, tail), latch rollback_index and enter WALK next cycle; if rollback_index equals tail index (nothing younger) remain IDLE with no kill.
REQ-020 SHALL in WALK assert kill_map_valid every cycle with fields from entry tail-1 (combinational from storage), and decrement tail at the edge.
REQ-021 SHALL leave WALK for IDLE in the cycle the emitted entry index equals the latched rollback_index.
REQ-022 SHALL produce the first kill the cycle after rollback acceptance; N killed entries take exactly N cycles, youngest first.
REQ-023 SHALL ignore rollback_valid while in WALK; busy = state==WALK.
REQ-024 SHALL accept commits during WALK; caller guarantees commits never reach the latched rollback_index.
REQ-025 SHALL hold kill_map_* fields at zero when kill_map_valid is low.
REQ-026 SHALL handle index wrap-around at DEPTH-1 -> 0 for head, tail, and walk.

Reset
REQ-027 SHALL on RST high at a rising edge set head=tail=0, state=IDLE; outputs then: empty=1, full=0, busy=0, record_ready=1, record_index=0, kill_map_valid=0, commit_free_valid=0.
REQ-028 SHALL abort any walk in progress on reset; storage contents need not be cleared.

Configuration
REQ-029 SHALL, with MAP_HISTORY_CHECK_EN defined, include simulation checks printing "ERROR: map_history_buffer.sv: ..." on: record while full, rollback_index outside [head, tail), rollback during WALK, commit while empty.
REQ-030 SHALL, without MAP_HISTORY_CHECK_EN, contain no checks; functional behaviour identical.

Structure
REQ-031 SHALL take arch_reg_tag_t, phys_reg_tag_t from instr_types_pkg; SHALL add hist_index_t and MAP_HIST_DEPTH to that package.
REQ-032 SHALL be a single module; no sub-module.

Verification
REQ-033 Reset, then 3 records (arch 1/2/3, old 1/2/3, new 33/34/35) -> record_index 0,1,2; empty=0.
REQ-034 Commit x2 -> commit_free_phys_reg_tag 1 then 2 on consecutive cycles; head=2.
REQ-035 Entries 0..4 (new 40..44), rollback_index=2 -> kills new 44,43,42 on cycles +1,+2,+3; busy 3 cycles; record_index=2 after.
REQ-036 DEPTH=16 fill 16 -> full=1, record_ready=0; commit+record same cycle -> full stays 1.
REQ-037 Head=14, records across wrap to index 1, rollback_index=15 -> kills indices 1,0,15 in that order.
REQ-038 Reset asserted mid-walk -> next cycle kill_map_valid=0, busy=0, empty=1.

Source files
------------

// File: rtl/instr_types_pkg.sv
// Shared rename-stage types: architectural/physical register tags plus the
// map-history index, pointer and entry types used by map_history_buffer.
package instr_types_pkg;

   localparam int MAP_HIST_DEPTH = 16;

   typedef logic [4:0] arch_reg_tag_t;
   typedef logic [5:0] phys_reg_tag_t;

   typedef logic [$clog2(MAP_HIST_DEPTH)-1:0] hist_index_t;
   // One extra MSB so head == tail means empty and a pure MSB difference means full.
   typedef logic [$clog2(MAP_HIST_DEPTH):0]   hist_ptr_t;

   typedef struct packed {
      arch_reg_tag_t arch_reg_tag;
      phys_reg_tag_t old_phys_reg_tag;
      phys_reg_tag_t new_phys_reg_tag;
   } hist_entry_t;

   typedef enum logic {
      HIST_IDLE = 1'b0,
      HIST_WALK = 1'b1
   } hist_state_t;

   function automatic hist_index_t ptr_index(input hist_ptr_t ptr);
      return ptr[$bits(hist_index_t)-1:0];
   endfunction

endpackage

// File: rtl/map_history_buffer_if.sv
// Record / commit / rollback / undo-stream bundle of map_history_buffer.
// The slave modport is the buffer side; the master modport is rename/ROB control.
interface map_history_buffer_if;
   import instr_types_pkg::*;

   logic          record_valid;
   logic          record_ready;
   arch_reg_tag_t record_arch_reg_tag;
   phys_reg_tag_t record_old_phys_reg_tag;
   phys_reg_tag_t record_new_phys_reg_tag;
   hist_index_t   record_index;

   logic          commit_valid;
   logic          commit_free_valid;
   phys_reg_tag_t commit_free_phys_reg_tag;

   logic          rollback_valid;
   hist_index_t   rollback_index;

   logic          kill_map_valid;
   arch_reg_tag_t kill_map_dest_arch_reg_tag;
   phys_reg_tag_t kill_map_old_dest_phys_reg_tag;
   phys_reg_tag_t kill_map_new_dest_phys_reg_tag;

   logic          busy;
   logic          empty;
   logic          full;

   modport slave (
      input  record_valid, record_arch_reg_tag, record_old_phys_reg_tag,
             record_new_phys_reg_tag, commit_valid, rollback_valid, rollback_index,
      output record_ready, record_index, commit_free_valid, commit_free_phys_reg_tag,
             kill_map_valid, kill_map_dest_arch_reg_tag, kill_map_old_dest_phys_reg_tag,
             kill_map_new_dest_phys_reg_tag, busy, empty, full
   );

   modport master (
      output record_valid, record_arch_reg_tag, record_old_phys_reg_tag,
             record_new_phys_reg_tag, commit_valid, rollback_valid, rollback_index,
      input  record_ready, record_index, commit_free_valid, commit_free_phys_reg_tag,
             kill_map_valid, kill_map_dest_arch_reg_tag, kill_map_old_dest_phys_reg_tag,
             kill_map_new_dest_phys_reg_tag, busy, empty, full
   );

endinterface

// File: rtl/map_history_buffer.sv
// Rename map history: circular log of replaced mappings, retired from the head
// and unwound youngest-first on rollback. Define MAP_HISTORY_CHECK_EN for protocol checks.
module map_history_buffer
   import instr_types_pkg::*;
#(
   parameter int DEPTH = MAP_HIST_DEPTH
) (
   input  logic                 CLK,
   input  logic                 RST,
   map_history_buffer_if.slave  hist
);

   hist_entry_t mem_r [DEPTH];
   hist_ptr_t   head_r;
   hist_ptr_t   tail_r;
   hist_state_t state_r;
   hist_state_t state_next_s;
   hist_index_t rb_index_r;

   hist_index_t head_idx_s;
   hist_index_t tail_idx_s;
   hist_index_t last_idx_s;
   hist_index_t rb_dist_s;
   hist_ptr_t   count_s;
   logic        empty_s;
   logic        full_s;
   logic        in_range_s;
   logic        record_ready_s;
   logic        record_fire_s;
   logic        commit_fire_s;
   logic        rb_accept_s;
   logic        kill_valid_s;
   hist_entry_t kill_entry_s;
   hist_entry_t record_entry_s;

   assign head_idx_s = ptr_index(head_r);
   assign tail_idx_s = ptr_index(tail_r);
   assign last_idx_s = tail_idx_s - hist_index_t'(1);
   assign count_s    = tail_r - head_r;
   assign empty_s    = (head_r == tail_r);
   assign full_s     = (head_idx_s == tail_idx_s) && (head_r[$bits(hist_index_t)] != tail_r[$bits(hist_index_t)]);

   // Distance from head, modulo DEPTH, lets one compare cover the wrapped window.
   assign rb_dist_s  = hist.rollback_index - head_idx_s;
   assign in_range_s = ({1'b0, rb_dist_s} < count_s);

   assign record_ready_s = ~full_s & (state_r == HIST_IDLE) & ~hist.rollback_valid;
   assign record_fire_s  = hist.record_valid & record_ready_s;
   assign commit_fire_s  = hist.commit_valid & ~empty_s;

   assign record_entry_s = '{arch_reg_tag:     hist.record_arch_reg_tag,
                             old_phys_reg_tag: hist.record_old_phys_reg_tag,
                             new_phys_reg_tag: hist.record_new_phys_reg_tag};

   // Next-state and undo-stream generation.
   always_comb begin
      state_next_s = state_r;
      rb_accept_s  = 1'b0;
      kill_valid_s = 1'b0;
      kill_entry_s = '0;
      case (state_r)
         HIST_IDLE: begin
            if (hist.rollback_valid && in_range_s) begin
               rb_accept_s  = 1'b1;
               state_next_s = HIST_WALK;
            end else begin
               state_next_s = HIST_IDLE;
            end
         end
         HIST_WALK: begin
            kill_valid_s = 1'b1;
            kill_entry_s = mem_r[last_idx_s];
            if (last_idx_s == rb_index_r) begin
               state_next_s = HIST_IDLE;
            end else begin
               state_next_s = HIST_WALK;
            end
         end
         default: begin
            state_next_s = HIST_IDLE;
         end
      endcase
   end

   // State, pointers and latched rollback target.
   always_ff @(posedge CLK) begin
      if (RST) begin
         head_r     <= '0;
         tail_r     <= '0;
         state_r    <= HIST_IDLE;
         rb_index_r <= '0;
      end else begin
         state_r <= state_next_s;
         if (commit_fire_s) begin
            head_r <= head_r + hist_ptr_t'(1);
         end
         if (record_fire_s) begin
            tail_r <= tail_r + hist_ptr_t'(1);
         end else if (state_r == HIST_WALK) begin
            tail_r <= tail_r - hist_ptr_t'(1);
         end
         if (rb_accept_s) begin
            rb_index_r <= hist.rollback_index;
         end
      end
   end

   // Entry storage; contents survive reset.
   always_ff @(posedge CLK) begin
      if (record_fire_s) begin
         mem_r[tail_idx_s] <= record_entry_s;
      end
   end

   assign hist.record_ready                   = record_ready_s;
   assign hist.record_index                   = tail_idx_s;
   assign hist.commit_free_valid              = commit_fire_s;
   assign hist.commit_free_phys_reg_tag       = mem_r[head_idx_s].old_phys_reg_tag;
   assign hist.kill_map_valid                 = kill_valid_s;
   assign hist.kill_map_dest_arch_reg_tag     = kill_entry_s.arch_reg_tag;
   assign hist.kill_map_old_dest_phys_reg_tag = kill_entry_s.old_phys_reg_tag;
   assign hist.kill_map_new_dest_phys_reg_tag = kill_entry_s.new_phys_reg_tag;
   assign hist.busy                           = (state_r == HIST_WALK);
   assign hist.empty                          = empty_s;
   assign hist.full                           = full_s;

`ifdef MAP_HISTORY_CHECK_EN
   // Caller protocol violations; a rollback to the tail index is legal and kills nothing.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (hist.record_valid && full_s) begin
            $display("ERROR: map_history_buffer.sv: record while full");
         end
         if (hist.rollback_valid && (state_r == HIST_IDLE) && !in_range_s
             && (hist.rollback_index != tail_idx_s)) begin
            $display("ERROR: map_history_buffer.sv: rollback_index %0d outside [head, tail)",
                     hist.rollback_index);
         end
         if (hist.rollback_valid && (state_r == HIST_WALK)) begin
            $display("ERROR: map_history_buffer.sv: rollback during WALK");
         end
         if (hist.commit_valid && empty_s) begin
            $display("ERROR: map_history_buffer.sv: commit while empty");
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_map_history_buffer.sv
// Scoreboard bench for map_history_buffer: stimulus pushes expected frees/kills,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_map_history_buffer;
   import instr_types_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   bit   mon_en = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   hist_entry_t   kill_q[$];
   phys_reg_tag_t commit_q[$];

   map_history_buffer_if hist();

   map_history_buffer #(.DEPTH(16)) dut (
      .CLK  (CLK),
      .RST  (RST),
      .hist (hist)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every presented free/kill must match the next queued expectation.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (hist.kill_map_valid) begin
            if (kill_q.size() == 0) begin
               chk("kill_unexpected", int'(hist.kill_map_valid), 0);
            end else begin
               hist_entry_t e;
               e = kill_q.pop_front();
               chk("kill_arch", int'(hist.kill_map_dest_arch_reg_tag), int'(e.arch_reg_tag));
               chk("kill_old",  int'(hist.kill_map_old_dest_phys_reg_tag), int'(e.old_phys_reg_tag));
               chk("kill_new",  int'(hist.kill_map_new_dest_phys_reg_tag), int'(e.new_phys_reg_tag));
            end
         end else begin
            chk("kill_idle_zero", int'({hist.kill_map_dest_arch_reg_tag,
                                        hist.kill_map_old_dest_phys_reg_tag,
                                        hist.kill_map_new_dest_phys_reg_tag}), 0);
         end
         if (hist.commit_free_valid) begin
            if (commit_q.size() == 0) begin
               chk("free_unexpected", int'(hist.commit_free_valid), 0);
            end else begin
               chk("free_tag", int'(hist.commit_free_phys_reg_tag), int'(commit_q.pop_front()));
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic rec(input int a, input int o, input int n, input int exp_idx);
      hist.record_valid            = 1'b1;
      hist.record_arch_reg_tag     = arch_reg_tag_t'(a);
      hist.record_old_phys_reg_tag = phys_reg_tag_t'(o);
      hist.record_new_phys_reg_tag = phys_reg_tag_t'(n);
      #1;
      chk("record_ready", int'(hist.record_ready), 1);
      chk("record_index", int'(hist.record_index), exp_idx);
      @(posedge CLK);
      #1;
      hist.record_valid = 1'b0;
   endtask

   task automatic cmt(input int exp_tag);
      hist.commit_valid = 1'b1;
      commit_q.push_back(phys_reg_tag_t'(exp_tag));
      tick();
      hist.commit_valid = 1'b0;
   endtask

   task automatic push_kill(input int a, input int o, input int n);
      hist_entry_t e;
      e.arch_reg_tag     = arch_reg_tag_t'(a);
      e.old_phys_reg_tag = phys_reg_tag_t'(o);
      e.new_phys_reg_tag = phys_reg_tag_t'(n);
      kill_q.push_back(e);
   endtask

   task automatic rollback(input int idx, input int n_kills);
      int cnt;
      hist.rollback_valid = 1'b1;
      hist.rollback_index = hist_index_t'(idx);
      tick();
      hist.rollback_valid = 1'b0;
      cnt = 0;
      while (hist.busy && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("busy_cycles", cnt, n_kills);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      hist.record_valid            = 1'b0;
      hist.record_arch_reg_tag     = '0;
      hist.record_old_phys_reg_tag = '0;
      hist.record_new_phys_reg_tag = '0;
      hist.commit_valid            = 1'b0;
      hist.rollback_valid          = 1'b0;
      hist.rollback_index          = '0;
      tick();
      RST    = 1'b0;
      mon_en = 1'b1;

      // Reset state
      chk("rst_empty", int'(hist.empty), 1);
      chk("rst_full", int'(hist.full), 0);
      chk("rst_busy", int'(hist.busy), 0);
      chk("rst_record_ready", int'(hist.record_ready), 1);
      chk("rst_record_index", int'(hist.record_index), 0);
      chk("rst_kill_valid", int'(hist.kill_map_valid), 0);
      chk("rst_free_valid", int'(hist.commit_free_valid), 0);

      // Three records, then commits free old tags in order
      rec(1, 1, 33, 0);
      rec(2, 2, 34, 1);
      rec(3, 3, 35, 2);
      chk("rec3_empty", int'(hist.empty), 0);
      cmt(1);
      cmt(2);
      chk("head2_record_index", int'(hist.record_index), 3);
      cmt(3);
      chk("drained_empty", int'(hist.empty), 1);
      hist.commit_valid = 1'b1;
      #1;
      chk("commit_empty_ignored", int'(hist.commit_free_valid), 0);
      tick();
      hist.commit_valid = 1'b0;
      chk("commit_empty_still_empty", int'(hist.empty), 1);

      // Rollback over entries 2..4 of 0..4
      do_reset();
      for (int i = 0; i < 5; i++) rec(10 + i, 20 + i, 40 + i, i);
      push_kill(14, 24, 44);
      push_kill(13, 23, 43);
      push_kill(12, 22, 42);
      rollback(2, 3);
      chk("rb_record_index", int'(hist.record_index), 2);
      rollback(2, 0);
      chk("rb_tail_noop_index", int'(hist.record_index), 2);
      rollback(7, 0);
      chk("rb_outside_noop_index", int'(hist.record_index), 2);

      // Fill to full; commit with record in the same cycle
      do_reset();
      for (int i = 0; i < 16; i++) rec(i, i + 1, 32 + i, i);
      chk("fill_full", int'(hist.full), 1);
      hist.record_valid            = 1'b1;
      hist.record_arch_reg_tag     = arch_reg_tag_t'(9);
      hist.record_old_phys_reg_tag = phys_reg_tag_t'(50);
      hist.record_new_phys_reg_tag = phys_reg_tag_t'(51);
      #1;
      chk("full_record_ready", int'(hist.record_ready), 0);
      hist.commit_valid = 1'b1;
      commit_q.push_back(phys_reg_tag_t'(1));
      #1;
      chk("full_commit_same_cycle_full", int'(hist.full), 1);
      chk("full_commit_same_cycle_ready", int'(hist.record_ready), 0);
      tick();
      hist.commit_valid = 1'b0;
      chk("after_commit_full", int'(hist.full), 0);
      chk("after_commit_ready", int'(hist.record_ready), 1);
      chk("after_commit_index", int'(hist.record_index), 0);
      tick();
      hist.record_valid = 1'b0;
      chk("refill_full", int'(hist.full), 1);

      // Wrap: head at 14, records at 14,15,0,1, rollback to 15
      do_reset();
      for (int i = 0; i < 14; i++) rec(i, i + 1, 32 + i, i);
      for (int i = 0; i < 14; i++) cmt(i + 1);
      chk("wrap_empty", int'(hist.empty), 1);
      rec(1, 50, 60, 14);
      rec(2, 51, 61, 15);
      rec(3, 52, 62, 0);
      rec(4, 53, 63, 1);
      push_kill(4, 53, 63);
      push_kill(3, 52, 62);
      push_kill(2, 51, 61);
      rollback(15, 3);
      chk("wrap_record_index", int'(hist.record_index), 15);
      chk("wrap_not_empty", int'(hist.empty), 0);

      // Reset in the middle of a walk
      do_reset();
      for (int i = 0; i < 5; i++) rec(20 + i, 30 + i, 40 + i, i);
      push_kill(24, 34, 44);
      push_kill(23, 33, 43);
      hist.rollback_valid = 1'b1;
      hist.rollback_index = hist_index_t'(0);
      tick();
      hist.rollback_valid = 1'b0;
      chk("midwalk_busy", int'(hist.busy), 1);
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("midwalk_rst_kill", int'(hist.kill_map_valid), 0);
      chk("midwalk_rst_busy", int'(hist.busy), 0);
      chk("midwalk_rst_empty", int'(hist.empty), 1);
      tick();

      chk("kill_q_drained", kill_q.size(), 0);
      chk("commit_q_drained", commit_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
